// File: rtl/rf_wb_ctrl_if.sv
// Writeback-controller bundle: ALU result, load issue/return handshake, hazard check and RF write port.
// Defines the rf_op encodings shared by the controller and its consumers.
`ifndef RF_WB_OPS_DEFINED
`define RF_WB_OPS_DEFINED
`define RD1_3R 2'd0
`define WR_1   2'd1
`endif

interface rf_wb_ctrl_if;
  logic        alu_valid;
  logic [4:0]  alu_wr;
  logic [31:0] alu_data;
  logic        alu_link;

  logic        ld_issue;
  logic [4:0]  ld_wr;

  logic        ld_ret_valid;
  logic        ld_ret_ready;
  logic [4:0]  ld_ret_wr;
  logic [31:0] ld_ret_data;

  logic [4:0]  chk_r1;
  logic [4:0]  chk_r2;
  logic        stall;

  logic        we;
  logic [4:0]  wR;
  logic [31:0] wD;
  logic [1:0]  rf_op;

  logic [2:0]  ld_cnt;
  logic        fwd1_hit;
  logic        fwd2_hit;

  modport master (
    output alu_valid, alu_wr, alu_data, alu_link,
    output ld_issue, ld_wr,
    output ld_ret_valid, ld_ret_wr, ld_ret_data,
    output chk_r1, chk_r2,
    input  ld_ret_ready, stall, we, wR, wD, rf_op, ld_cnt, fwd1_hit, fwd2_hit
  );

  modport slave (
    input  alu_valid, alu_wr, alu_data, alu_link,
    input  ld_issue, ld_wr,
    input  ld_ret_valid, ld_ret_wr, ld_ret_data,
    input  chk_r1, chk_r2,
    output ld_ret_ready, stall, we, wR, wD, rf_op, ld_cnt, fwd1_hit, fwd2_hit
  );
endinterface

// File: rtl/rf_wb_ctrl.sv
// Register-file writeback arbiter (ALU over 4-deep load-return FIFO, 1-cycle registered write) with load scoreboard.
// ld_ret_ready drops when the FIFO holds 4; optional WB_BYPASS_EN adds forwarding hits and stall suppression.
module rf_wb_ctrl (
  input  logic        clk,
  input  logic        rst,
  rf_wb_ctrl_if.slave bus
);

  typedef struct packed {
    logic [4:0]  wr;
    logic [31:0] data;
  } ret_ent_t;

  ret_ent_t    fifo_q [4];
  ret_ent_t    head;
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] busy_q, busy_d;
  logic [31:0] set_vec, clr_vec;

  logic        we_q, we_d;
  logic [4:0]  wr_q, wr_d;
  logic [31:0] wd_q, wd_d;
  logic [1:0]  op_q, op_d;

  logic        push, pop, fifo_empty;
  logic        src1_stall, src2_stall;

  assign fifo_empty       = (cnt_q == 3'd0);
  assign bus.ld_ret_ready = (cnt_q != 3'd4);
  // Gating with rst keeps storage untouched while the block is held in reset.
  assign push             = bus.ld_ret_valid & bus.ld_ret_ready & ~rst;
  assign pop              = ~bus.alu_valid & ~fifo_empty;
  assign head             = fifo_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= '{wr: bus.ld_ret_wr, data: bus.ld_ret_data};
    end
  end

  // ALU has absolute priority; an idle cycle only drops we and holds the rest.
  always_comb begin
    we_d = 1'b0;
    wr_d = wr_q;
    wd_d = wd_q;
    op_d = op_q;
    if (bus.alu_valid) begin
      we_d = 1'b1;
      wr_d = bus.alu_link ? 5'd1 : bus.alu_wr;
      wd_d = bus.alu_data;
      op_d = bus.alu_link ? `WR_1 : `RD1_3R;
    end else if (pop) begin
      we_d = 1'b1;
      wr_d = head.wr;
      wd_d = head.data;
      op_d = `RD1_3R;
    end
  end

  // Only load pops retire a pending load; a same-cycle issue re-arms the bit.
  always_comb begin
    set_vec = bus.ld_issue ? (32'd1 << bus.ld_wr) : 32'd0;
    clr_vec = pop ? (32'd1 << head.wr) : 32'd0;
    busy_d  = ((busy_q & ~clr_vec) | set_vec) & ~32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
      busy_q   <= 32'd0;
      we_q     <= 1'b0;
      wr_q     <= 5'd0;
      wd_q     <= 32'd0;
      op_q     <= `RD1_3R;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      we_q     <= we_d;
      wr_q     <= wr_d;
      wd_q     <= wd_d;
      op_q     <= op_d;
    end
  end

`ifdef WB_BYPASS_EN
  assign bus.fwd1_hit = we_q & (wr_q == bus.chk_r1) & (bus.chk_r1 != 5'd0);
  assign bus.fwd2_hit = we_q & (wr_q == bus.chk_r2) & (bus.chk_r2 != 5'd0);
  // A source is released early only if its bit really retires now, not re-set by a new issue.
  assign src1_stall = busy_q[bus.chk_r1] &
                      ~(bus.fwd1_hit & clr_vec[bus.chk_r1] & ~set_vec[bus.chk_r1]);
  assign src2_stall = busy_q[bus.chk_r2] &
                      ~(bus.fwd2_hit & clr_vec[bus.chk_r2] & ~set_vec[bus.chk_r2]);
`else
  assign bus.fwd1_hit = 1'b0;
  assign bus.fwd2_hit = 1'b0;
  assign src1_stall   = busy_q[bus.chk_r1];
  assign src2_stall   = busy_q[bus.chk_r2];
`endif

  assign bus.stall  = src1_stall | src2_stall;
  assign bus.we     = we_q;
  assign bus.wR     = wr_q;
  assign bus.wD     = wd_q;
  assign bus.rf_op  = op_q;
  assign bus.ld_cnt = cnt_q;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Directed bench for rf_wb_ctrl: reset, ALU/link writes, scoreboard, FIFO saturation/drain, reset flush.
module tb_rf_wb_ctrl;
  localparam logic [1:0] OP_RD1_3R = 2'd0;
  localparam logic [1:0] OP_WR_1   = 2'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  rf_wb_ctrl_if bus();
  rf_wb_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid    = 1'b0;
    bus.alu_wr       = 5'd0;
    bus.alu_data     = 32'd0;
    bus.alu_link     = 1'b0;
    bus.ld_issue     = 1'b0;
    bus.ld_wr        = 5'd0;
    bus.ld_ret_valid = 1'b0;
    bus.ld_ret_wr    = 5'd0;
    bus.ld_ret_data  = 32'd0;
    bus.chk_r1       = 5'd0;
    bus.chk_r2       = 5'd0;
  endtask

  task automatic test_reset();
    idle();
    tick();
    tick();
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL rst_we got=%0h exp=0", bus.we); end
    checks++; if (bus.wR !== 5'd0) begin errors++; $display("FAIL rst_wR got=%0h exp=0", bus.wR); end
    checks++; if (bus.wD !== 32'd0) begin errors++; $display("FAIL rst_wD got=%0h exp=0", bus.wD); end
    checks++; if (bus.rf_op !== OP_RD1_3R) begin errors++; $display("FAIL rst_op got=%0h exp=%0h", bus.rf_op, OP_RD1_3R); end
    checks++; if (bus.ld_cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt got=%0h exp=0", bus.ld_cnt); end
    checks++; if (bus.ld_ret_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0h exp=1", bus.ld_ret_ready); end
    checks++; if (bus.fwd1_hit !== 1'b0 || bus.fwd2_hit !== 1'b0) begin errors++; $display("FAIL rst_fwd got=%0h%0h exp=00", bus.fwd1_hit, bus.fwd2_hit); end
    // handshakes while in reset must be ignored
    bus.ld_ret_valid = 1'b1; bus.ld_ret_wr = 5'd8; bus.ld_ret_data = 32'h88;
    bus.ld_issue = 1'b1; bus.ld_wr = 5'd8;
    bus.alu_valid = 1'b1; bus.alu_wr = 5'd8;
    tick();
    bus.chk_r1 = 5'd8;
    #1;
    checks++; if (bus.ld_cnt !== 3'd0) begin errors++; $display("FAIL rst_hs_cnt got=%0h exp=0", bus.ld_cnt); end
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL rst_hs_we got=%0h exp=0", bus.we); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL rst_hs_stall got=%0h exp=0", bus.stall); end
    tick();
    idle();
    rst = 1'b0;
    tick();
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL post_rst_we got=%0h exp=0", bus.we); end
  endtask

  task automatic test_alu_write();
    bus.alu_valid = 1'b1; bus.alu_wr = 5'd5; bus.alu_data = 32'hDEADBEEF;
    tick();
    checks++; if (bus.we !== 1'b1) begin errors++; $display("FAIL alu_we got=%0h exp=1", bus.we); end
    checks++; if (bus.wR !== 5'd5) begin errors++; $display("FAIL alu_wR got=%0h exp=5", bus.wR); end
    checks++; if (bus.wD !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wD got=%0h exp=deadbeef", bus.wD); end
    checks++; if (bus.rf_op !== OP_RD1_3R) begin errors++; $display("FAIL alu_op got=%0h exp=%0h", bus.rf_op, OP_RD1_3R); end
    bus.alu_valid = 1'b0;
    tick();
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL idle_we got=%0h exp=0", bus.we); end
    checks++; if (bus.wR !== 5'd5 || bus.wD !== 32'hDEADBEEF) begin errors++; $display("FAIL idle_hold got=%0h/%0h exp=5/deadbeef", bus.wR, bus.wD); end
    bus.alu_valid = 1'b1; bus.alu_link = 1'b1; bus.alu_wr = 5'd7; bus.alu_data = 32'h1004;
    tick();
    checks++; if (bus.wR !== 5'd1) begin errors++; $display("FAIL link_wR got=%0h exp=1", bus.wR); end
    checks++; if (bus.rf_op !== OP_WR_1) begin errors++; $display("FAIL link_op got=%0h exp=%0h", bus.rf_op, OP_WR_1); end
    checks++; if (bus.wD !== 32'h1004) begin errors++; $display("FAIL link_wD got=%0h exp=1004", bus.wD); end
    bus.alu_link = 1'b0; bus.alu_wr = 5'd0; bus.alu_data = 32'h0BAD;
    tick();
    checks++; if (bus.we !== 1'b1 || bus.wR !== 5'd0) begin errors++; $display("FAIL r0_write got=%0h/%0h exp=1/0", bus.we, bus.wR); end
    checks++; if (bus.rf_op !== OP_RD1_3R) begin errors++; $display("FAIL r0_op got=%0h exp=%0h", bus.rf_op, OP_RD1_3R); end
    idle();
    tick();
  endtask

  task automatic test_scoreboard();
    bus.ld_issue = 1'b1; bus.ld_wr = 5'd3;
    tick();
    bus.ld_issue = 1'b0;
    bus.chk_r1 = 5'd3;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL sb_stall_r1 got=%0h exp=1", bus.stall); end
    bus.chk_r1 = 5'd0; bus.chk_r2 = 5'd3;
    #1;
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL sb_stall_r2 got=%0h exp=1", bus.stall); end
    bus.chk_r2 = 5'd0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL sb_nostall got=%0h exp=0", bus.stall); end
    bus.chk_r1 = 5'd3;
    bus.ld_ret_valid = 1'b1; bus.ld_ret_wr = 5'd3; bus.ld_ret_data = 32'h55;
    tick();
    bus.ld_ret_valid = 1'b0;
    #1;
    checks++; if (bus.ld_cnt !== 3'd1) begin errors++; $display("FAIL ret_cnt got=%0h exp=1", bus.ld_cnt); end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL ret_stall_hold got=%0h exp=1", bus.stall); end
    tick();
    checks++; if (bus.we !== 1'b1 || bus.wR !== 5'd3 || bus.wD !== 32'h55) begin errors++; $display("FAIL ret_write got=%0h/%0h/%0h exp=1/3/55", bus.we, bus.wR, bus.wD); end
    checks++; if (bus.ld_cnt !== 3'd0) begin errors++; $display("FAIL ret_cnt0 got=%0h exp=0", bus.ld_cnt); end
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL ret_stall_clr got=%0h exp=0", bus.stall); end
    idle();
    bus.ld_issue = 1'b1; bus.ld_wr = 5'd0;
    tick();
    bus.ld_issue = 1'b0;
    #1;
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL r0_nostall got=%0h exp=0", bus.stall); end
  endtask

  task automatic test_busy_rules();
    idle();
    bus.ld_issue = 1'b1; bus.ld_wr = 5'd4;
    tick();
    bus.ld_issue = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_wr = 5'd4; bus.alu_data = 32'h44;
    tick();
    bus.alu_valid = 1'b0;
    bus.chk_r1 = 5'd4;
    #1;
    checks++; if (bus.we !== 1'b1 || bus.wR !== 5'd4) begin errors++; $display("FAIL alubusy_write got=%0h/%0h exp=1/4", bus.we, bus.wR); end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL alubusy_stall got=%0h exp=1", bus.stall); end
    bus.ld_ret_valid = 1'b1; bus.ld_ret_wr = 5'd4; bus.ld_ret_data = 32'hAA;
    tick();
    bus.ld_ret_valid = 1'b0;
    bus.ld_issue = 1'b1; bus.ld_wr = 5'd4;
    tick();
    bus.ld_issue = 1'b0;
    #1;
    checks++; if (bus.wR !== 5'd4 || bus.wD !== 32'hAA) begin errors++; $display("FAIL setwin_write got=%0h/%0h exp=4/aa", bus.wR, bus.wD); end
    checks++; if (bus.stall !== 1'b1) begin errors++; $display("FAIL setwin_stall got=%0h exp=1", bus.stall); end
    bus.ld_ret_valid = 1'b1; bus.ld_ret_wr = 5'd4; bus.ld_ret_data = 32'hBB;
    tick();
    bus.ld_ret_valid = 1'b0;
    tick();
    #1;
    checks++; if (bus.wD !== 32'hBB || bus.stall !== 1'b0) begin errors++; $display("FAIL second_pop got=%0h/%0h exp=bb/0", bus.wD, bus.stall); end
    bus.chk_r1 = 5'd6;
    bus.ld_ret_valid = 1'b1; bus.ld_ret_wr = 5'd6; bus.ld_ret_data = 32'h66;
    tick();
    bus.ld_ret_valid = 1'b0;
    tick();
    #1;
    checks++; if (bus.we !== 1'b1 || bus.wR !== 5'd6 || bus.wD !== 32'h66) begin errors++; $display("FAIL nonbusy_pop got=%0h/%0h/%0h exp=1/6/66", bus.we, bus.wR, bus.wD); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL nonbusy_stall got=%0h exp=0", bus.stall); end
    bus.ld_ret_valid = 1'b1; bus.ld_ret_wr = 5'd7; bus.ld_ret_data = 32'h70;
    tick();
    bus.ld_ret_wr = 5'd8; bus.ld_ret_data = 32'h80;
    tick();
    bus.ld_ret_valid = 1'b0;
    checks++; if (bus.ld_cnt !== 3'd1 || bus.wR !== 5'd7) begin errors++; $display("FAIL pushpop got=%0h/%0h exp=1/7", bus.ld_cnt, bus.wR); end
    tick();
    checks++; if (bus.ld_cnt !== 3'd0 || bus.wR !== 5'd8 || bus.wD !== 32'h80) begin errors++; $display("FAIL pushpop_drain got=%0h/%0h/%0h exp=0/8/80", bus.ld_cnt, bus.wR, bus.wD); end
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    idle();
    bus.alu_valid = 1'b1; bus.alu_wr = 5'd2; bus.alu_data = 32'h2;
    for (int i = 0; i < 5; i++) begin
      bus.ld_ret_valid = 1'b1; bus.ld_ret_wr = 5'(16 + i); bus.ld_ret_data = 32'h100 + i;
      #1;
      checks++; if (bus.ld_ret_ready !== (i < 4)) begin errors++; $display("FAIL b2b_ready[%0d] got=%0h exp=%0h", i, bus.ld_ret_ready, (i < 4)); end
      tick();
      checks++; if (bus.ld_cnt !== 3'((i < 4) ? i + 1 : 4)) begin errors++; $display("FAIL b2b_cnt[%0d] got=%0h exp=%0h", i, bus.ld_cnt, ((i < 4) ? i + 1 : 4)); end
    end
    checks++; if (bus.we !== 1'b1 || bus.wR !== 5'd2) begin errors++; $display("FAIL b2b_alu got=%0h/%0h exp=1/2", bus.we, bus.wR); end
    idle();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (bus.we !== 1'b1 || bus.wR !== 5'(16 + i) || bus.wD !== 32'h100 + i) begin errors++; $display("FAIL drain[%0d] got=%0h/%0h/%0h exp=1/%0h/%0h", i, bus.we, bus.wR, bus.wD, 16 + i, 32'h100 + i); end
      checks++; if (bus.ld_cnt !== 3'(3 - i)) begin errors++; $display("FAIL drain_cnt[%0d] got=%0h exp=%0h", i, bus.ld_cnt, 3 - i); end
    end
    tick();
    checks++; if (bus.we !== 1'b0 || bus.ld_cnt !== 3'd0) begin errors++; $display("FAIL drain_done got=%0h/%0h exp=0/0", bus.we, bus.ld_cnt); end
  endtask

  task automatic test_reset_flush();
    idle();
    bus.ld_issue = 1'b1; bus.ld_wr = 5'd9;
    tick();
    bus.ld_issue = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_wr = 5'd1;
    for (int i = 0; i < 3; i++) begin
      bus.ld_ret_valid = 1'b1; bus.ld_ret_wr = 5'(20 + i); bus.ld_ret_data = 32'h200 + i;
      tick();
    end
    bus.ld_ret_valid = 1'b0;
    bus.chk_r1 = 5'd9;
    #1;
    checks++; if (bus.ld_cnt !== 3'd3 || bus.stall !== 1'b1) begin errors++; $display("FAIL flush_pre got=%0h/%0h exp=3/1", bus.ld_cnt, bus.stall); end
    #1;
    rst = 1'b1;
    #1;
    checks++; if (bus.ld_cnt !== 3'd0) begin errors++; $display("FAIL flush_cnt got=%0h exp=0", bus.ld_cnt); end
    checks++; if (bus.stall !== 1'b0) begin errors++; $display("FAIL flush_stall got=%0h exp=0", bus.stall); end
    checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL flush_we got=%0h exp=0", bus.we); end
    checks++; if (bus.ld_ret_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%0h exp=1", bus.ld_ret_ready); end
    bus.alu_valid = 1'b0;
    bus.ld_ret_valid = 1'b1; bus.ld_ret_wr = 5'd30; bus.ld_ret_data = 32'h300;
    tick();
    tick();
    idle();
    rst = 1'b0;
    bus.chk_r1 = 5'd9;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (bus.we !== 1'b0) begin errors++; $display("FAIL post_flush_we[%0d] got=%0h exp=0", i, bus.we); end
    end
    checks++; if (bus.ld_cnt !== 3'd0 || bus.stall !== 1'b0) begin errors++; $display("FAIL post_flush_state got=%0h/%0h exp=0/0", bus.ld_cnt, bus.stall); end
  endtask

  initial begin
    test_reset();
    test_alu_write();
    test_scoreboard();
    test_busy_rules();
    test_back_to_back();
    test_reset_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rf_wb_ctrl.md
RF_WB_CTRL -- requirements
Module: rf_wb_ctrl

Interface
REQ-001 clk  in  1  single clock; all state updates on posedge clk.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 alu_valid  in  1  ALU result present this cycle.
REQ-004 alu_wr  in  5  ALU destination register.
REQ-005 alu_data  in  32  ALU result.
REQ-006 alu_link  in  1  link write; destination forced to r1.
REQ-007 ld_issue  in  1  load issued this cycle; marks ld_wr pending.
REQ-008 ld_wr  in  5  destination of issued load.
REQ-009 ld_ret_valid / ld_ret_ready  in / out  1 / 1  load-return handshake.
REQ-010 ld_ret_wr / ld_ret_data  in  5 / 32  load-return destination and data.
REQ-011 chk_r1 / chk_r2  in  5 / 5  source registers of the instruction being decoded.
REQ-012 stall  out  1  a source register has a pending load.
REQ-013 we / wR / wD / rf_op  out  1 / 5 / 32 / 2  register-file write port.
REQ-014 ld_cnt  out  3  return-FIFO occupancy, 0..4.
REQ-015 fwd1_hit / fwd2_hit  out  1 / 1  forwarding hit on chk_r1 / chk_r2 (see Configuration).

Function
REQ-016 Return FIFO SHALL be 4 entries x 37 bits {wr, data} with 2-bit read/write pointers wrapping 3->0.
REQ-017 ld_ret_ready SHALL equal (ld_cnt != 4); no same-cycle pass-through when full.
REQ-018 Push on ld_ret_valid & ld_ret_ready; simultaneous push and pop SHALL leave ld_cnt unchanged.
REQ-019 Arbiter per cycle: alu_valid wins; else FIFO non-empty pops head; else idle.
REQ-020 Write outputs SHALL be registered: selected source appears on we/wR/wD exactly 1 cycle after selection.
REQ-021 ALU write: wR = alu_link ? 1 : alu_wr; rf_op = alu_link ? `WR_1 : `RD1_3R.
REQ-022 FIFO write: wR = head wr, rf_op = `RD1_3R.
REQ-023 Idle cycle: we = 0; wR, wD, rf_op hold previous values.
REQ-024 Writes with destination r0 (non-link) SHALL still be issued with we = 1; the register file discards them.
REQ-025 Scoreboard busy[31:0]: ld_issue sets busy[ld_wr]; FIFO pop clears busy[head wr].
REQ-026 busy[0] SHALL remain 0.
REQ-027 Set and clear of the same bit in one cycle: set wins.
REQ-028 stall = busy[chk_r1] | busy[chk_r2], combinational; r0 never stalls.
REQ-029 ALU write to a busy register SHALL NOT clear busy.
REQ-030 Later load pop overwrites it (in-order, last-writer-by-time).
REQ-031 Pop into a non-busy register: write still performed, busy unchanged.

Reset
REQ-032 rst SHALL asynchronously clear: FIFO pointers, ld_cnt = 0, busy = 0, we = 0, wR = 0, wD = 0, rf_op = `RD1_3R.
REQ-033 rst SHALL force ld_ret_ready = 1 and stall = 0.
REQ-034 In-flight FIFO contents are discarded on reset and never written.
REQ-035 Handshakes presented during rst SHALL be ignored.

Configuration
REQ-036 Macro WB_BYPASS_EN.
REQ-037 Defined: fwd1_hit = we & (wR == chk_r1) & (chk_r1 != 0); fwd2_hit likewise for chk_r2.
REQ-038 Defined: stall is suppressed for a source whose hit is asserted and whose busy bit clears this cycle.
REQ-039 Undefined: fwd1_hit = fwd2_hit = 0 and stall is purely the scoreboard per REQ-028.

Verification
REQ-040 alu_valid=1, alu_wr=5, alu_data=0xDEADBEEF -> next cycle we=1, wR=5, wD=0xDEADBEEF, rf_op=`RD1_3R.
REQ-041 alu_valid=1, alu_link=1, alu_wr=7, alu_data=0x1004 -> next cycle wR=1, rf_op=`WR_1.
REQ-042 ld_issue ld_wr=3 -> chk_r1=3 gives stall=1.
REQ-043 Return {3, 0x55} with alu idle -> push, pop, we=1, wR=3, wD=0x55; stall drops once busy[3] clears.
REQ-044 Hold alu_valid=1 while pushing 5 returns -> ld_cnt saturates at 4, ld_ret_ready=0 on the 5th.
REQ-045 Release alu_valid -> FIFO drains in order over 4 cycles.
REQ-046 Assert rst with ld_cnt=3 and busy[9]=1 -> immediately ld_cnt=0, busy=0, we=0, ld_ret_ready=1.
REQ-047 No buffered write is issued after rst releases.
